// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions for the writeback stage: datapath width,
// load funct3 encodings and the writeback FSM state type.
package riscv_pkg;

  localparam int RV_XLEN = 32;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic {
    IDLE      = 1'b0,
    WAIT_LOAD = 1'b1
  } wb_state_t;

endpackage

// File: rtl/wb_stage_load_align.sv
// Purely combinational load data extraction and sign/zero extension,
// plus misalignment and illegal-funct3 detection for the writeback stage.
module load_align
  import riscv_pkg::*;
(
  input  logic [RV_XLEN-1:0] word,
  input  logic [2:0]         funct3,
  input  logic [1:0]         addr_lo,
  output logic [RV_XLEN-1:0] data,
  output logic               misaligned,
  output logic               illegal
);

  logic [RV_XLEN-1:0] w_shift;

  // Move the addressed byte/halfword down to bit 0 before extending.
  assign w_shift = word >> {addr_lo, 3'b000};

  always_comb begin
    data       = '0;
    misaligned = 1'b0;
    illegal    = 1'b0;
    case (funct3)
      F3_LB:  data = {{24{w_shift[7]}}, w_shift[7:0]};
      F3_LBU: data = {24'd0, w_shift[7:0]};
      F3_LH: begin
        data       = {{16{w_shift[15]}}, w_shift[15:0]};
        misaligned = (addr_lo == 2'd3);
      end
      F3_LHU: begin
        data       = {16'd0, w_shift[15:0]};
        misaligned = (addr_lo == 2'd3);
      end
      F3_LW: begin
        data       = word;
        misaligned = (addr_lo != 2'd0);
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: registers ALU results, waits for and aligns load data,
// flags dropped loads. Optional forwarding ports under WB_BYPASS_EN.
module wb_stage
  import riscv_pkg::*;
#(
  parameter int          XLEN         = 32,
  parameter int unsigned LOAD_TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,
  // ex_ready is high exactly in IDLE; ex_* is consumed on any edge where
  // ex_valid && ex_ready, and ignored otherwise.
  input  logic            ex_valid,
  output logic            ex_ready,
  input  logic [4:0]      ex_rd,
  input  logic [XLEN-1:0] ex_result,
  input  logic            ex_is_load,
  input  logic [2:0]      ex_funct3,
  input  logic [1:0]      ex_addr_lo,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            rf_we,
  output logic [4:0]      rf_rd,
  output logic [XLEN-1:0] rf_wdata,
  output logic            load_err,
`ifdef WB_BYPASS_EN
  input  logic [4:0]      rs1_addr,
  input  logic [4:0]      rs2_addr,
  output logic            fwd_rs1_hit,
  output logic            fwd_rs2_hit,
  output logic [XLEN-1:0] fwd_data,
`endif
  output wb_state_t       dbg_state
);

  wb_state_t       r_state;
  wb_state_t       w_state_nxt;
  logic [7:0]      r_cnt;
  logic [4:0]      r_ld_rd;
  logic [2:0]      r_ld_f3;
  logic [1:0]      r_ld_alo;
  logic            r_we;
  logic [4:0]      r_rd;
  logic [XLEN-1:0] r_wdata;
  logic            r_err;

  logic            w_capture;
  logic            w_we_nxt;
  logic [4:0]      w_rd_nxt;
  logic [XLEN-1:0] w_wdata_nxt;
  logic            w_err_set;
  logic            w_timeout;
  logic [XLEN-1:0] w_ld_data;
  logic            w_ld_mis;
  logic            w_ld_ill;

  load_align u_load_align (
    .word       (mem_rdata),
    .funct3     (r_ld_f3),
    .addr_lo    (r_ld_alo),
    .data       (w_ld_data),
    .misaligned (w_ld_mis),
    .illegal    (w_ld_ill)
  );

  // Last permitted WAIT_LOAD cycle; a response in this cycle still wins.
  assign w_timeout = (r_cnt == 8'(LOAD_TIMEOUT - 1));

  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_we_nxt    = 1'b0;
    w_rd_nxt    = r_rd;
    w_wdata_nxt = r_wdata;
    w_err_set   = 1'b0;
    case (r_state)
      IDLE: begin
        if (ex_valid) begin
          if (ex_is_load) begin
            w_capture   = 1'b1;
            w_state_nxt = WAIT_LOAD;
          end else if (ex_rd != 5'd0) begin
            w_we_nxt    = 1'b1;
            w_rd_nxt    = ex_rd;
            w_wdata_nxt = ex_result;
          end
        end
      end
      WAIT_LOAD: begin
        if (mem_rvalid) begin
          w_state_nxt = IDLE;
          if (w_ld_mis || w_ld_ill) begin
            w_err_set = 1'b1;
          end else if (r_ld_rd != 5'd0) begin
            w_we_nxt    = 1'b1;
            w_rd_nxt    = r_ld_rd;
            w_wdata_nxt = w_ld_data;
          end
        end else if (w_timeout) begin
          w_state_nxt = IDLE;
          w_err_set   = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_cnt    <= 8'd0;
      r_ld_rd  <= 5'd0;
      r_ld_f3  <= 3'd0;
      r_ld_alo <= 2'd0;
      r_we     <= 1'b0;
      r_rd     <= 5'd0;
      r_wdata  <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_we    <= w_we_nxt;
      r_rd    <= w_rd_nxt;
      r_wdata <= w_wdata_nxt;
      if (w_err_set) r_err <= 1'b1;
      if (w_capture) begin
        r_cnt    <= 8'd0;
        r_ld_rd  <= ex_rd;
        r_ld_f3  <= ex_funct3;
        r_ld_alo <= ex_addr_lo;
      end else if (r_state == WAIT_LOAD) begin
        r_cnt <= r_cnt + 8'd1;
      end
    end
  end

  assign ex_ready  = (r_state == IDLE);
  assign rf_we     = r_we;
  assign rf_rd     = r_rd;
  assign rf_wdata  = r_wdata;
  assign load_err  = r_err;
  assign dbg_state = r_state;

`ifdef WB_BYPASS_EN
  assign fwd_rs1_hit = r_we && (r_rd != 5'd0) && (r_rd == rs1_addr);
  assign fwd_rs2_hit = r_we && (r_rd != 5'd0) && (r_rd == rs2_addr);
  assign fwd_data    = r_wdata;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Directed self-checking bench for wb_stage (LOAD_TIMEOUT=4); covers
// WB_BYPASS_EN ports when that macro is defined.
module tb_wb_stage;
  import riscv_pkg::*;

  logic        clk;
  logic        rst;
  logic        ex_valid;
  logic        ex_ready;
  logic [4:0]  ex_rd;
  logic [31:0] ex_result;
  logic        ex_is_load;
  logic [2:0]  ex_funct3;
  logic [1:0]  ex_addr_lo;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wdata;
  logic        load_err;
  wb_state_t   dbg_state;
`ifdef WB_BYPASS_EN
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic        fwd_rs1_hit;
  logic        fwd_rs2_hit;
  logic [31:0] fwd_data;
`endif

  int checks   = 0;
  int failures = 0;
  logic [36:0] exp_q[$];

  wb_stage #(.XLEN(32), .LOAD_TIMEOUT(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .ex_valid   (ex_valid),
    .ex_ready   (ex_ready),
    .ex_rd      (ex_rd),
    .ex_result  (ex_result),
    .ex_is_load (ex_is_load),
    .ex_funct3  (ex_funct3),
    .ex_addr_lo (ex_addr_lo),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .rf_we      (rf_we),
    .rf_rd      (rf_rd),
    .rf_wdata   (rf_wdata),
    .load_err   (load_err),
`ifdef WB_BYPASS_EN
    .rs1_addr   (rs1_addr),
    .rs2_addr   (rs2_addr),
    .fwd_rs1_hit(fwd_rs1_hit),
    .fwd_rs2_hit(fwd_rs2_hit),
    .fwd_data   (fwd_data),
`endif
    .dbg_state  (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Scoreboard: every observed register-file write must match the next expected one.
  always @(negedge clk) begin
    if (!rst && rf_we) begin
      if (exp_q.size() == 0) begin
        check("stray_we", 32'(rf_rd), 32'hFFFF_FFFF);
      end else begin
        logic [36:0] e;
        e = exp_q.pop_front();
        check("wb_rd", 32'(rf_rd), 32'(e[36:32]));
        check("wb_data", rf_wdata, e[31:0]);
      end
    end
  end

  // Driver tasks: called at a negedge, return at a negedge.
  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic alu(input logic [4:0] rd, input logic [31:0] res);
    ex_valid   = 1'b1;
    ex_is_load = 1'b0;
    ex_rd      = rd;
    ex_result  = res;
    if (rd != 5'd0) exp_q.push_back({rd, res});
    @(negedge clk);
    ex_valid = 1'b0;
    check("alu_we", 32'(rf_we), 32'(rd != 5'd0));
  endtask

  // Response arrives in WAIT_LOAD cycle 'cyc' (1 = first cycle after acceptance).
  task automatic load(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] alo,
                      input logic [31:0] word, input int cyc,
                      input logic exp_we, input logic [31:0] exp_data);
    ex_valid   = 1'b1;
    ex_is_load = 1'b1;
    ex_rd      = rd;
    ex_funct3  = f3;
    ex_addr_lo = alo;
    @(negedge clk);
    ex_is_load = 1'b0;
    ex_rd      = 5'd9;
    ex_result  = 32'hBAD0_BAD0;
    check("ld_ready0", 32'(ex_ready), 32'd0);
    repeat (cyc - 1) @(negedge clk);
    mem_rvalid = 1'b1;
    mem_rdata  = word;
    if (exp_we) exp_q.push_back({rd, exp_data});
    @(negedge clk);
    mem_rvalid = 1'b0;
    ex_valid   = 1'b0;
    check("ld_we", 32'(rf_we), 32'(exp_we));
    check("ld_ready1", 32'(ex_ready), 32'd1);
  endtask

  initial begin
    rst        = 1'b1;
    ex_valid   = 1'b0;
    ex_rd      = 5'd0;
    ex_result  = 32'd0;
    ex_is_load = 1'b0;
    ex_funct3  = 3'd0;
    ex_addr_lo = 2'd0;
    mem_rvalid = 1'b0;
    mem_rdata  = 32'd0;
`ifdef WB_BYPASS_EN
    rs1_addr   = 5'd0;
    rs2_addr   = 5'd0;
`endif
    repeat (2) @(negedge clk);
    check("rst_we", 32'(rf_we), 32'd0);
    check("rst_rd", 32'(rf_rd), 32'd0);
    check("rst_wdata", rf_wdata, 32'd0);
    check("rst_err", 32'(load_err), 32'd0);
    check("rst_ready", 32'(ex_ready), 32'd1);
    rst = 1'b0;
    @(negedge clk);

    // ALU write and one-cycle pulse
    alu(5'd5, 32'hDEAD_BEEF);
    check("alu_rd", 32'(rf_rd), 32'd5);
    check("alu_data", rf_wdata, 32'hDEAD_BEEF);
    @(negedge clk);
    check("alu_pulse", 32'(rf_we), 32'd0);

`ifdef WB_BYPASS_EN
    rs1_addr = 5'd7;
    rs2_addr = 5'd0;
    alu(5'd7, 32'h0000_7777);
    check("fwd_rs1_hit", 32'(fwd_rs1_hit), 32'd1);
    check("fwd_rs2_hit", 32'(fwd_rs2_hit), 32'd0);
    check("fwd_data", fwd_data, 32'h0000_7777);
    @(negedge clk);
    check("fwd_idle", 32'(fwd_rs1_hit), 32'd0);
`endif

    // Load extraction/extension; cycle 4 coincides with the timeout cycle
    load(5'd3, F3_LB, 2'd3, 32'h80FF_0000, 4, 1'b1, 32'hFFFF_FF80);
    check("boundary_err", 32'(load_err), 32'd0);
    load(5'd4, F3_LBU, 2'd3, 32'h80FF_0000, 4, 1'b1, 32'h0000_0080);
    load(5'd6, F3_LHU, 2'd2, 32'h8001_1234, 2, 1'b1, 32'h0000_8001);
    load(5'd8, F3_LH, 2'd1, 32'h1280_0134, 1, 1'b1, 32'hFFFF_8001);
    load(5'd10, F3_LW, 2'd0, 32'hCAFE_F00D, 3, 1'b1, 32'hCAFE_F00D);
    load(5'd0, F3_LW, 2'd0, 32'h1111_2222, 1, 1'b0, 32'd0);
    check("x0_load_err", 32'(load_err), 32'd0);

    // x0 ALU write suppressed
    alu(5'd0, 32'h0000_1234);
    @(negedge clk);
    check("x0_alu_we", 32'(rf_we), 32'd0);

    // Reset during WAIT_LOAD, then a stale response
    ex_valid   = 1'b1;
    ex_is_load = 1'b1;
    ex_rd      = 5'd11;
    ex_funct3  = F3_LW;
    ex_addr_lo = 2'd0;
    @(negedge clk);
    ex_valid = 1'b0;
    check("st_wait", 32'(dbg_state), 32'(WAIT_LOAD));
    rst = 1'b1;
    @(negedge clk);
    check("rstw_ready", 32'(ex_ready), 32'd1);
    check("rstw_we", 32'(rf_we), 32'd0);
    rst        = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h5555_AAAA;
    @(negedge clk);
    mem_rvalid = 1'b0;
    @(negedge clk);
    check("stale_we", 32'(rf_we), 32'd0);
    check("stale_ready", 32'(ex_ready), 32'd1);
    check("stale_err", 32'(load_err), 32'd0);

    // Timeout with no response, then a late response
    ex_valid   = 1'b1;
    ex_is_load = 1'b1;
    ex_rd      = 5'd12;
    ex_funct3  = F3_LW;
    ex_addr_lo = 2'd0;
    @(negedge clk);
    ex_valid = 1'b0;
    check("to_c1_ready", 32'(ex_ready), 32'd0);
    repeat (3) @(negedge clk);
    check("to_c4_ready", 32'(ex_ready), 32'd0);
    check("to_c4_err", 32'(load_err), 32'd0);
    @(negedge clk);
    check("to_ready", 32'(ex_ready), 32'd1);
    check("to_err", 32'(load_err), 32'd1);
    check("to_we", 32'(rf_we), 32'd0);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h7777_8888;
    @(negedge clk);
    mem_rvalid = 1'b0;
    check("late_we", 32'(rf_we), 32'd0);
    check("late_ready", 32'(ex_ready), 32'd1);

    // Error cases, each from a clean reset
    do_reset();
    check("clr_err", 32'(load_err), 32'd0);
    load(5'd13, F3_LW, 2'd1, 32'h1234_5678, 1, 1'b0, 32'd0);
    check("mis_err", 32'(load_err), 32'd1);
    do_reset();
    load(5'd14, 3'b011, 2'd0, 32'h1234_5678, 2, 1'b0, 32'd0);
    check("ill_err", 32'(load_err), 32'd1);
    for (int i = 0; i < 10; i++) begin
      alu(5'(i + 1), 32'(i) * 32'h1111_1111);
    end
    @(negedge clk);
    check("sticky_err", 32'(load_err), 32'd1);

    repeat (2) @(negedge clk);
    check("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 Parameter XLEN, default 32: datapath width; only 32 is supported.
REQ-002 Parameter LOAD_TIMEOUT, default 255: WAIT_LOAD cycles before a load is abandoned; legal range 1..255.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  reset; asynchronous, active-high.
REQ-005 ex_valid  in  1  execute stage presents an instruction.
REQ-006 ex_ready  out  1  stage accepts ex_* this cycle.
REQ-007 ex_rd  in  5  destination register index.
REQ-008 ex_result  in  32  ALU result for a non-load instruction.
REQ-009 ex_is_load  in  1  the instruction is a load.
REQ-010 ex_funct3  in  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
REQ-011 ex_addr_lo  in  2  load byte offset, address bits [1:0].
REQ-012 mem_rvalid  in  1  data memory load response valid.
REQ-013 mem_rdata  in  32  aligned data-memory word.
REQ-014 rf_we  out  1  register-file write enable.
REQ-015 rf_rd  out  5  register-file write address.
REQ-016 rf_wdata  out  32  register-file write data.
REQ-017 load_err  out  1  sticky error flag for a dropped load.

Function
REQ-018 The FSM SHALL have two states: IDLE and WAIT_LOAD.
REQ-019 ex_ready SHALL equal 1 in IDLE and 0 in WAIT_LOAD.
REQ-020 IDLE, ex_valid=1, ex_is_load=0: the stage SHALL register rf_we=1, rf_rd=ex_rd and rf_wdata=ex_result, visible the next cycle (latency 1), and SHALL remain in IDLE.
REQ-021 IDLE, ex_valid=1, ex_is_load=1: the stage SHALL capture ex_rd, ex_funct3 and ex_addr_lo, clear the timeout counter and enter WAIT_LOAD.
REQ-022 WAIT_LOAD, mem_rvalid=1: the stage SHALL extract the byte or halfword at ex_addr_lo, zero-extend it for LBU/LHU or sign-extend it for LB/LH, pass the whole word for LW, and register the write, visible the next cycle; it then returns to IDLE.
REQ-023 rf_we SHALL be a one-cycle pulse and SHALL be 0 in every cycle that does not follow a completed write per REQ-020 or REQ-022.
REQ-024 A destination of rd=0 SHALL never produce rf_we=1; the instruction otherwise completes normally.
REQ-025 A load whose funct3 is 011, 110 or 111 SHALL suppress the write and set load_err.
REQ-026 A misaligned load SHALL suppress the write and set load_err: LH/LHU with addr_lo=3, or LW with addr_lo≠0.
REQ-027 The error check in REQ-025/REQ-026 SHALL be applied when the load completes.
REQ-028 The WAIT_LOAD counter SHALL increment each cycle; on reaching LOAD_TIMEOUT without mem_rvalid, the stage SHALL return to IDLE, suppress the write and set load_err.
REQ-029 If mem_rvalid and the timeout occur in the same cycle, the data SHALL win and no error is raised.
REQ-030 mem_rvalid in IDLE SHALL be ignored, including a stale response arriving after a timeout or reset.
REQ-031 ex_* inputs in WAIT_LOAD SHALL be ignored.
REQ-032 load_err SHALL remain set until reset.

Reset
REQ-033 rst SHALL immediately force: state=IDLE, rf_we=0, rf_rd=0, rf_wdata=0, load_err=0 and counter=0.
REQ-034 Reset during WAIT_LOAD SHALL abandon the load with no write.

Configuration
REQ-035 With WB_BYPASS_EN defined, the stage SHALL add the following ports:
- inputs rs1_addr[5] and rs2_addr[5];
- outputs fwd_rs1_hit, fwd_rs2_hit and fwd_data[32].
REQ-036 With WB_BYPASS_EN defined, fwd_rsN_hit SHALL be combinationally 1 when rf_we=1, rf_rd≠0 and rf_rd=rsN_addr; fwd_data SHALL equal rf_wdata.
REQ-037 Without WB_BYPASS_EN, these ports and their logic SHALL be absent.

Structure
REQ-038 The shared package riscv_pkg SHALL hold the following items:
- the load funct3 constants;
- the wb_state_t enum (IDLE, WAIT_LOAD);
- the XLEN constant.
REQ-039 One sub-module, load_align, SHALL contain the purely combinational extract and extend logic.
- Inputs: word, funct3, addr_lo.
- Outputs: data, misaligned, illegal.

Verification
REQ-040 ALU write: ex_rd=5, ex_result=0xDEADBEEF, ex_is_load=0 -> next cycle rf_we=1, rf_rd=5, rf_wdata=0xDEADBEEF; the following cycle rf_we=0.
REQ-041 Load extension: LB, addr_lo=3, mem_rdata=0x80FF_0000 after 4 cycles -> rf_wdata=0xFFFFFF80. The same stimulus with LBU -> 0x00000080. LHU, addr_lo=2, mem_rdata=0x8001_1234 -> rf_wdata=0x00008001.
REQ-042 Error cases:
- LW with addr_lo=1 -> no rf_we, load_err=1.
- funct3=011 -> no rf_we, load_err=1.
- load_err still 1 after 10 further valid instructions.
REQ-043 Timeout, with LOAD_TIMEOUT=4: no mem_rvalid -> IDLE after 4 cycles, load_err=1, no rf_we, and a late mem_rvalid is ignored. mem_rvalid exactly on cycle 4 -> write occurs and load_err=0.
REQ-044 Reset and x0:
- rst asserted in WAIT_LOAD, then a response -> no rf_we and ex_ready=1.
- ALU write with ex_rd=0, result 0x1234 -> rf_we stays 0.
REQ-045 With WB_BYPASS_EN defined: rf_rd=7 and rs1_addr=7 -> fwd_rs1_hit=1 and fwd_data=rf_wdata; rs2_addr=0 -> fwd_rs2_hit=0.
